// File: rtl/tdea_host_ctrl.sv
// Host-side sequencer for a TDEA core: loads a key triple, feeds one block at a
// time, captures the core result and flags rejected requests or core timeouts.
module tdea_host_ctrl #(
   parameter int unsigned TMO_MAX = 63
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        KeyStart,
   input  logic [63:0] K1,
   input  logic [63:0] K2,
   input  logic [63:0] K3,
   input  logic        Mode,
   input  logic        DataStart,
   input  logic [63:0] DataIn,
   output logic        Busy,
   output logic [63:0] Result,
   output logic        ResultVld,
   output logic        Err,
   output logic        KeyLoaded,
   output logic [63:0] Din,
   output logic [63:0] Kin,
   output logic        Drdy,
   output logic        Krdy,
   output logic        EncDec,
   output logic        EN,
   input  logic [63:0] Dout_c,
   input  logic        Dvld_c,
   input  logic        BSY_c,
   input  logic        Kvld_c
);

   localparam logic [7:0] TMO_LIM = TMO_MAX[7:0];

   typedef enum logic [2:0] {
      IDLE, KEY1, KEY2, KEY3, KWAIT, DREQ, DWAIT, DONE
   } state_t;

   state_t      state_q, state_d;
   logic [63:0] k2_q, k2_d, k3_q, k3_d;
   logic [63:0] kin_q, kin_d, din_q, din_d, result_q, result_d;
   logic        mode_q, mode_d, err_q, err_d, keyld_q, keyld_d, en_q;
   logic [7:0]  cnt_q, cnt_d, cnt_inc;

   assign cnt_inc = cnt_q + 8'd1;

   always_comb begin
      state_d  = state_q;
      k2_d     = k2_q;
      k3_d     = k3_q;
      kin_d    = kin_q;
      din_d    = din_q;
      result_d = result_q;
      mode_d   = mode_q;
      keyld_d  = keyld_q;
      cnt_d    = cnt_q;
      err_d    = 1'b0;
      Krdy     = 1'b0;
      Drdy     = 1'b0;
      unique case (state_q)
         IDLE: begin
            // A key request wins over a simultaneous data request, which is flagged.
            if (KeyStart) begin
               kin_d   = K1;
               k2_d    = K2;
               k3_d    = K3;
               mode_d  = Mode;
               keyld_d = 1'b0;
               err_d   = DataStart;
               state_d = KEY1;
            end else if (DataStart) begin
               if (keyld_q) begin
                  din_d   = DataIn;
                  mode_d  = Mode;
                  state_d = DREQ;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         KEY1: begin
            Krdy    = 1'b1;
            kin_d   = k2_q;
            state_d = KEY2;
         end
         KEY2: begin
            Krdy    = 1'b1;
            kin_d   = k3_q;
            state_d = KEY3;
         end
         KEY3: begin
            Krdy    = 1'b1;
            cnt_d   = 8'd0;
            state_d = KWAIT;
         end
         KWAIT: begin
            cnt_d = cnt_inc;
            if (Kvld_c) begin
               keyld_d = 1'b1;
               state_d = IDLE;
            end else if (cnt_inc == TMO_LIM) begin
               err_d   = 1'b1;
               keyld_d = 1'b0;
               state_d = IDLE;
            end
         end
         DREQ: begin
            if (!BSY_c) begin
               Drdy    = 1'b1;
               cnt_d   = 8'd0;
               state_d = DWAIT;
            end
         end
         DWAIT: begin
            // A valid arriving on the last allowed cycle still beats the timeout.
            cnt_d = cnt_inc;
            if (Dvld_c) begin
               result_d = Dout_c;
               state_d  = DONE;
            end else if (cnt_inc == TMO_LIM) begin
               err_d   = 1'b1;
               keyld_d = 1'b0;
               state_d = IDLE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         kin_q    <= '0;
         din_q    <= '0;
         result_q <= '0;
         mode_q   <= 1'b0;
         err_q    <= 1'b0;
         keyld_q  <= 1'b0;
         en_q     <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         kin_q    <= kin_d;
         din_q    <= din_d;
         result_q <= result_d;
         mode_q   <= mode_d;
         err_q    <= err_d;
         keyld_q  <= keyld_d;
         en_q     <= 1'b1;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge CLK) begin
      k2_q <= k2_d;
      k3_q <= k3_d;
   end

   assign Busy      = (state_q != IDLE);
   assign ResultVld = (state_q == DONE);
   assign Result    = result_q;
   assign Err       = err_q;
   assign KeyLoaded = keyld_q;
   assign Din       = din_q;
   assign Kin       = kin_q;
   assign EncDec    = mode_q;
   assign EN        = en_q;

endmodule

// File: doc/tdea_host_ctrl.md
TDEA_HOST_CTRL -- requirements
Module: tdea_host_ctrl

Interface
REQ-001 SHALL have parameter TMO_MAX, default 63, meaning the maximum cycles to wait for Kvld_c or Dvld_c before timeout (range 49..255).
REQ-002 SHALL have port CLK, input, 1, the single system clock; all logic rises on CLK.
REQ-003 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-004 SHALL have port KeyStart, input, 1, a one-cycle host request to load a key triple.
REQ-005 SHALL have ports K1, K2, K3, input, 64 each, key words [1:64], sampled on an accepted KeyStart.
REQ-006 SHALL have port Mode, input, 1, 0 = encrypt and 1 = decrypt, sampled on an accepted KeyStart or DataStart.
REQ-007 SHALL have port DataStart, input, 1, a one-cycle host request to process one block.
REQ-008 SHALL have port DataIn, input, 64, the block sampled on an accepted DataStart.
REQ-009 SHALL have port Busy, output, 1, high whenever the FSM is not IDLE.
REQ-010 SHALL have port Result, output, 64, the last captured core output.
REQ-011 SHALL have port ResultVld, output, 1, a one-cycle pulse when Result updates.
REQ-012 SHALL have port Err, output, 1, a one-cycle pulse on a rejected request or a timeout.
REQ-013 SHALL have port KeyLoaded, output, 1, high while a valid key triple resides in the core.
REQ-014 SHALL have core-side outputs Din (64), Kin (64), Drdy (1), Krdy (1), EncDec (1) and EN (1).
REQ-015 SHALL have core-side inputs Dout_c (64), Dvld_c (1), BSY_c (1) and Kvld_c (1).

Function
REQ-016 SHALL implement the states IDLE, KEY1, KEY2, KEY3, KWAIT, DREQ, DWAIT and DONE.
REQ-017 SHALL, in IDLE with KeyStart=1, latch K1/K2/K3/Mode, clear KeyLoaded and go to KEY1 on the next edge.
REQ-018 SHALL hold Krdy=1 in KEY1, KEY2 and KEY3 (exactly three consecutive cycles), with Kin=K1, K2 and K3 respectively.
REQ-019 SHALL go KEY1->KEY2->KEY3->KWAIT unconditionally, with Krdy=0 in KWAIT.
REQ-020 SHALL, in KWAIT, on Kvld_c=1, set KeyLoaded=1 and return to IDLE.
REQ-021 SHALL, in IDLE with DataStart=1 and KeyLoaded=1, latch DataIn/Mode and go to DREQ.
REQ-022 SHALL, in DREQ, assert Drdy=1 with Din=the latched block only while BSY_c=0, for exactly one cycle, then go to DWAIT; while BSY_c=1 it SHALL hold in DREQ with Drdy=0.
REQ-023 SHALL, in DWAIT, on Dvld_c=1, capture Dout_c into Result and go to DONE.
REQ-024 SHALL pulse ResultVld=1 for one cycle in DONE with Result already valid, then return to IDLE.
REQ-025 SHALL drive EncDec from the latched Mode in every state and hold EN=1 except during reset.
REQ-026 SHALL, for DataStart with KeyLoaded=0 in IDLE, ignore the request and pulse Err.
REQ-027 SHALL, when KeyStart and DataStart are both 1 in IDLE, accept the key, drop the data request and pulse Err.
REQ-028 SHALL ignore KeyStart/DataStart while Busy=1, with no Err and no effect.
REQ-029 SHALL count cycles with an 8-bit counter in KWAIT and DWAIT, cleared on state entry.
REQ-030 SHALL, when the counter reaches TMO_MAX without the awaited valid, pulse Err, clear KeyLoaded and go to IDLE.
REQ-031 SHALL ignore Dvld_c and Kvld_c in states other than KWAIT and DWAIT.
REQ-032 SHALL keep Kin and Din held at their last driven values when not in use.

Reset
REQ-033 SHALL, on RST=1 at a CLK edge (including mid-operation), enter IDLE.
REQ-034 SHALL reset Busy, ResultVld, Err, KeyLoaded, Drdy, Krdy, EncDec and EN to 0.
REQ-035 SHALL reset Result, Din and Kin to 0 and the timeout counter to 0.
REQ-036 SHALL drive EN=1 from the first cycle after RST deasserts.

Verification
REQ-037 SHALL be verified with K1=K2=K3=10316E028C8F3B4A, Mode=0, DataIn=0 against the TDEA core: Krdy high for exactly 3 cycles with Kin sequence correct, then Result=82DCBAFBDEAB6602 with a single ResultVld pulse.
REQ-038 SHALL be verified with keys 0123456789ABCDEF/23456789ABCDEF01/456789ABCDEF0123, Mode=0, blocks 5468652071756663, 6B2062726F776E20, 666F78206A756D70: Results A826FD8CE53B855F, CCE21C8112256FE6, 68D5C05DD9B6B900; Mode=1 with those Results returns the plaintexts.
REQ-039 SHALL be verified with DataStart after reset (KeyLoaded=0): Err pulses once, Drdy stays 0 and Busy stays 0.
REQ-040 SHALL be verified with a stub core that never asserts Dvld_c: Err pulses exactly TMO_MAX cycles after DWAIT entry, KeyLoaded=0 and the FSM is in IDLE.
REQ-041 SHALL be verified with RST asserted during KEY2: next cycle Krdy=0, Busy=0, KeyLoaded=0; a following DataStart gives an Err pulse.
REQ-042 SHALL be verified with BSY_c held high for 5 cycles in DREQ: Drdy stays 0 throughout, then rises for exactly one cycle after BSY_c falls.
